// File: rtl/colour_seq_pkg.sv
// Shared types and colour-code constants for the colour sequencer.
// COLOUR_SEQ_SKIP_BLACK_WHITE_EN restricts the running sequence to codes 1..6.
package colour_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam int unsigned COLOUR_W = 3;

    localparam logic [COLOUR_W-1:0] COLOUR_IDLE       = 3'd0;
    localparam logic [COLOUR_W-1:0] COLOUR_FIRST_FULL = 3'd0;
    localparam logic [COLOUR_W-1:0] COLOUR_LAST_FULL  = 3'd7;
    localparam logic [COLOUR_W-1:0] COLOUR_FIRST_SKIP = 3'd1;
    localparam logic [COLOUR_W-1:0] COLOUR_LAST_SKIP  = 3'd6;

`ifdef COLOUR_SEQ_SKIP_BLACK_WHITE_EN
    localparam logic [COLOUR_W-1:0] COLOUR_FIRST = COLOUR_FIRST_SKIP;
    localparam logic [COLOUR_W-1:0] COLOUR_LAST  = COLOUR_LAST_SKIP;
`else
    localparam logic [COLOUR_W-1:0] COLOUR_FIRST = COLOUR_FIRST_FULL;
    localparam logic [COLOUR_W-1:0] COLOUR_LAST  = COLOUR_LAST_FULL;
`endif

    function automatic logic [COLOUR_W-1:0] next_colour(input logic [COLOUR_W-1:0] c);
        if (c == COLOUR_LAST) begin
            return COLOUR_FIRST;
        end
        return c + 3'd1;
    endfunction

endpackage

// File: rtl/colour_sequencer_dwell_timer.sv
// Dwell counter: counts 0..DWELL-1 while run is high, holds otherwise.
// expired flags the terminal count so the owner can advance on that edge.
module dwell_timer #(
    parameter int unsigned DWELL = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic clear,
    output logic expired
);

    localparam int unsigned W = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [W-1:0] LAST = W'(DWELL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign expired = run && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (run) begin
            cnt_d = expired ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/colour_sequencer.sv
// Colour sequencer: IDLE/RUN/PAUSE FSM stepping a 3-bit colour code, auto or manual.
// Define COLOUR_SEQ_SKIP_BLACK_WHITE_EN to cycle codes 1..6 instead of 0..7.
module colour_sequencer
    import colour_seq_pkg::*;
#(
    parameter int unsigned DWELL = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                step_mode,
    input  logic                step,
    output logic [COLOUR_W-1:0] colour,
    output logic                enable,
    output logic                busy,
    output logic                wrap
);

    state_t                state_q, state_d;
    logic [COLOUR_W-1:0]   colour_q, colour_d;
    logic                  enable_q, enable_d;
    logic                  busy_q, busy_d;
    logic                  wrap_q, wrap_d;

    logic                  tmr_run;
    logic                  tmr_clear;
    logic                  tmr_expired;
    logic                  advance;
    logic [COLOUR_W-1:0]   colour_next;

    dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .run     (tmr_run),
        .clear   (tmr_clear),
        .expired (tmr_expired)
    );

    assign colour_next = next_colour(colour_q);

    // stop always takes priority over start, so both high behaves as stop.
    always_comb begin
        state_d   = state_q;
        colour_d  = colour_q;
        wrap_d    = 1'b0;
        advance   = 1'b0;
        tmr_run   = 1'b0;
        tmr_clear = 1'b0;

        case (state_q)
            IDLE: begin
                colour_d  = COLOUR_IDLE;
                tmr_clear = 1'b1;
                if (start && !stop) begin
                    state_d  = RUN;
                    colour_d = COLOUR_FIRST;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = PAUSE;
                end else if (step_mode) begin
                    advance = step;
                end else begin
                    tmr_run = 1'b1;
                    advance = tmr_expired;
                end
            end
            PAUSE: begin
                if (stop) begin
                    state_d   = IDLE;
                    colour_d  = COLOUR_IDLE;
                    tmr_clear = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d   = IDLE;
                colour_d  = COLOUR_IDLE;
                tmr_clear = 1'b1;
            end
        endcase

        if (advance) begin
            colour_d = colour_next;
            wrap_d   = (colour_next == COLOUR_FIRST);
        end

        enable_d = (state_d == RUN);
        busy_d   = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            colour_q <= COLOUR_IDLE;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            colour_q <= colour_d;
            enable_q <= enable_d;
            busy_q   <= busy_d;
            wrap_q   <= wrap_d;
        end
    end

    assign colour = colour_q;
    assign enable = enable_q;
    assign busy   = busy_q;
    assign wrap   = wrap_q;

endmodule

// File: doc/colour_sequencer.md
COLOUR_SEQUENCER -- requirements
Module: colour_sequencer

Interface
REQ-001 The block SHALL have parameter DWELL, default 4: number of clk cycles each colour is held in auto mode; legal range 1..255.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: level request to run or resume the sequence.
REQ-005 The block SHALL have port stop, input, 1 bit: level request to pause (from RUN) or abort (from PAUSE).
REQ-006 The block SHALL have port step_mode, input, 1 bit: 1 = manual advance on step, 0 = auto advance every DWELL cycles.
REQ-007 The block SHALL have port step, input, 1 bit: single-cycle advance pulse, honoured only in RUN with step_mode=1.
REQ-008 The block SHALL have port colour, output, 3 bits: colour code driven to the RGB converter's colour input.
REQ-009 The block SHALL have port enable, output, 1 bit: drives the converter's enable input.
REQ-010 The block SHALL have port busy, output, 1 bit: high in RUN or PAUSE.
REQ-011 The block SHALL have port wrap, output, 1 bit: one-cycle pulse on the cycle colour returns to its first code.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and PAUSE; all outputs SHALL be registered.
REQ-013 IDLE SHALL drive colour=0, enable=0, busy=0 and wrap=0, and SHALL go to RUN on the cycle after start=1 with stop=0.
REQ-014 In RUN, enable=1 and busy=1 SHALL hold, with enable rising on the same edge the state becomes RUN.
REQ-015 In RUN with step_mode=0, the dwell counter SHALL count 0..DWELL-1; on the edge where it equals DWELL-1, colour SHALL advance and the counter SHALL clear.
REQ-016 The first advance after entering RUN from IDLE SHALL occur exactly DWELL cycles after enable rises.
REQ-017 With DWELL=1, colour SHALL advance every cycle.
REQ-018 In RUN with step_mode=1, the dwell counter SHALL hold, and colour SHALL advance one code per cycle on which step=1.
REQ-019 Colour advance SHALL be modulo 8 (7 -> 0); wrap SHALL pulse for one cycle coincident with colour becoming 0.
REQ-020 stop=1 in RUN SHALL move to PAUSE next cycle: enable=0, colour and dwell counter frozen, busy=1.
REQ-021 start=1 (with stop=0) in PAUSE SHALL return to RUN and resume the frozen counter value; no colour advance SHALL occur on the resume edge.
REQ-022 stop=1 in PAUSE SHALL return to IDLE with colour=0 and counter=0.
REQ-023 start and stop asserted together SHALL be treated as stop (stop wins).
REQ-024 Toggling step_mode mid-RUN SHALL take effect on the next edge without clearing the counter.
REQ-025 step outside RUN, or with step_mode=0, SHALL be ignored.

Reset
REQ-026 rst=1 on a rising edge SHALL force IDLE, colour=0, enable=0, busy=0, wrap=0 and counter=0 from any state, overriding all other inputs including mid-dwell.
REQ-027 The first cycle after rst deasserts SHALL observe inputs normally.

Configuration
REQ-028 With macro COLOUR_SEQ_SKIP_BLACK_WHITE_EN defined, advance SHALL cycle 1..6 only: 6 -> 1 raises wrap, leaving IDLE loads colour=1, and IDLE and reset still drive colour=0.
REQ-029 Without COLOUR_SEQ_SKIP_BLACK_WHITE_EN, the full 0..7 sequence of REQ-019 SHALL apply.

Structure
REQ-030 Package colour_seq_pkg SHALL hold the state enum (IDLE/RUN/PAUSE), COLOUR_W=3, and the first/last colour code constants for both macro settings.
REQ-031 The dwell counter SHALL be a sub-module dwell_timer (ports: clk, rst, run, clear, expired), sized by $clog2 of DWELL with a minimum width of 1.
REQ-032 colour and enable SHALL connect directly to the converter's colour and enable ports with no extra logic.

Verification
REQ-033 Bench SHALL cover: DWELL=4, step_mode=0, start 1 cycle -> enable rises next edge, colour 0,1,2 at +4 and +8 cycles, and wrap pulses once 32 cycles after enable rises.
REQ-034 Bench SHALL cover: stop in RUN at counter=2 with colour=3 -> enable=0 and colour=3 held 10 cycles; then start -> colour=4 exactly 2 cycles after resume.
REQ-035 Bench SHALL cover: step_mode=1 with 3 step pulses spaced 5 cycles -> colour 0 -> 3, one change per pulse, no auto advance.
REQ-036 Bench SHALL cover: start and stop high together in IDLE -> stays IDLE; same in RUN -> PAUSE.
REQ-037 Bench SHALL cover: rst asserted in RUN at colour=5 -> next edge colour=0, enable=0, busy=0, and wrap does not pulse.
REQ-038 Bench SHALL cover: with COLOUR_SEQ_SKIP_BLACK_WHITE_EN and DWELL=1 -> colour 1..6 repeating, 0 and 7 never seen while busy, and wrap pulses every 6 cycles.
